// File: rtl/clint_timer_pkg.sv
// Shared definitions for the core-local interruptor: register offsets, mip bit indices,
// bus FSM states and a byte-lane merge helper.
package clint_pkg;

    localparam logic [15:0] CLINT_MSIP        = 16'h0000;
    localparam logic [15:0] CLINT_MTIMECMP_LO = 16'h4000;
    localparam logic [15:0] CLINT_MTIMECMP_HI = 16'h4004;
    localparam logic [15:0] CLINT_MTIME_LO    = 16'hBFF8;
    localparam logic [15:0] CLINT_MTIME_HI    = 16'hBFFC;

    localparam int MXIP_EXT   = 0;
    localparam int MXIP_SW    = 1;
    localparam int MXIP_TIMER = 2;

    typedef enum logic {
        IDLE,
        RESP
    } bus_state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_timer_irq_sync.sv
// Multi-flop level synchroniser for an asynchronous interrupt line; all stages reset to 0.
module irq_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/msip registers behind a single-outstanding bus port.
// Optional CLINT_MTIME_SNAPSHOT_EN makes a low-word mtime read latch the high word for a coherent 64-bit read.
module clint_timer
    import clint_pkg::*;
#(
    parameter int PRESCALE    = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        ctrl_clk,
    input  logic        ctrl_reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic        mem_wen,
    input  logic [15:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_fault,
    input  logic        ext_irq,
    output logic [2:0]  ctrl_mxip
);

    bus_state_t  r_state;
    bus_state_t  w_state_next;
    logic        w_accept;
    logic        w_mapped;
    logic        w_wr;
    logic        w_rd;
    logic        w_tick;
    logic        w_ext_sync;
    logic [31:0] r_presc;
    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [63:0] w_mtime_next;
    logic [63:0] w_mtimecmp_next;
    logic        r_msip;
    logic        r_timer_irq;
    logic [31:0] r_rdata;
    logic [31:0] w_rdata_sel;
    logic        r_fault;
`ifdef CLINT_MTIME_SNAPSHOT_EN
    logic [31:0] r_shadow;
`endif

    always_comb begin
        w_accept = (r_state == IDLE) && mem_valid;
        w_mapped = (mem_addr[1:0] == 2'b00) &&
                   ((mem_addr == CLINT_MSIP)        || (mem_addr == CLINT_MTIMECMP_LO) ||
                    (mem_addr == CLINT_MTIMECMP_HI) || (mem_addr == CLINT_MTIME_LO)    ||
                    (mem_addr == CLINT_MTIME_HI));
        w_wr     = w_accept && mem_wen && w_mapped;
        w_rd     = w_accept && !mem_wen && w_mapped;
    end

    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (mem_valid) w_state_next = RESP;
            RESP: w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_ready = (r_state == RESP);
        mem_rdata = r_rdata;
        mem_fault = r_fault;
    end

    assign w_tick = (r_presc == 32'(PRESCALE - 1));

    // A bus write to either mtime word swallows a coincident tick so software sees exactly what it wrote.
    always_comb begin
        w_mtime_next = r_mtime;
        if (w_wr && (mem_addr == CLINT_MTIME_LO)) begin
            w_mtime_next[31:0] = merge_bytes(r_mtime[31:0], mem_wdata, mem_wstrb);
        end else if (w_wr && (mem_addr == CLINT_MTIME_HI)) begin
            w_mtime_next[63:32] = merge_bytes(r_mtime[63:32], mem_wdata, mem_wstrb);
        end else if (w_tick) begin
            w_mtime_next = r_mtime + 64'd1;
        end
    end

    always_comb begin
        w_mtimecmp_next = r_mtimecmp;
        if (w_wr && (mem_addr == CLINT_MTIMECMP_LO)) begin
            w_mtimecmp_next[31:0] = merge_bytes(r_mtimecmp[31:0], mem_wdata, mem_wstrb);
        end else if (w_wr && (mem_addr == CLINT_MTIMECMP_HI)) begin
            w_mtimecmp_next[63:32] = merge_bytes(r_mtimecmp[63:32], mem_wdata, mem_wstrb);
        end
    end

    always_comb begin
        w_rdata_sel = '0;
        case (mem_addr)
            CLINT_MSIP:        w_rdata_sel = {31'd0, r_msip};
            CLINT_MTIMECMP_LO: w_rdata_sel = r_mtimecmp[31:0];
            CLINT_MTIMECMP_HI: w_rdata_sel = r_mtimecmp[63:32];
            CLINT_MTIME_LO:    w_rdata_sel = r_mtime[31:0];
`ifdef CLINT_MTIME_SNAPSHOT_EN
            CLINT_MTIME_HI:    w_rdata_sel = r_shadow;
`else
            CLINT_MTIME_HI:    w_rdata_sel = r_mtime[63:32];
`endif
            default:           w_rdata_sel = '0;
        endcase
    end

    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_presc     <= '0;
            r_mtime     <= '0;
            r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip      <= 1'b0;
            r_timer_irq <= 1'b0;
            r_rdata     <= '0;
            r_fault     <= 1'b0;
        end else begin
            r_presc     <= w_tick ? 32'd0 : r_presc + 32'd1;
            r_mtime     <= w_mtime_next;
            r_mtimecmp  <= w_mtimecmp_next;
            r_timer_irq <= (r_mtime >= r_mtimecmp);
            r_rdata     <= w_rd ? w_rdata_sel : 32'd0;
            r_fault     <= w_accept && !w_mapped;
            if (w_wr && (mem_addr == CLINT_MSIP) && mem_wstrb[0]) begin
                r_msip <= mem_wdata[0];
            end
        end
    end

`ifdef CLINT_MTIME_SNAPSHOT_EN
    always_ff @(posedge ctrl_clk or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_shadow <= '0;
        end else if (w_rd && (mem_addr == CLINT_MTIME_LO)) begin
            r_shadow <= r_mtime[63:32];
        end
    end
`endif

    irq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_irq_sync (
        .i_clk   (ctrl_clk),
        .i_rst   (ctrl_reset),
        .i_async (ext_irq),
        .o_sync  (w_ext_sync)
    );

    always_comb begin
        ctrl_mxip             = '0;
        ctrl_mxip[MXIP_EXT]   = w_ext_sync;
        ctrl_mxip[MXIP_SW]    = r_msip;
        ctrl_mxip[MXIP_TIMER] = r_timer_irq;
    end

endmodule

// File: tb/tb_clint_timer.sv
// Directed self-checking bench for clint_timer (PRESCALE=4, SYNC_STAGES=2).
// Expected mtime high-word snapshot result follows CLINT_MTIME_SNAPSHOT_EN.
module tb_clint_timer;

    logic        ctrl_clk = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic        mem_wen = 1'b0;
    logic [15:0] mem_addr = '0;
    logic [3:0]  mem_wstrb = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] mem_rdata;
    logic        mem_fault;
    logic        ext_irq = 1'b0;
    logic [2:0]  ctrl_mxip;

    int checks = 0;
    int errors = 0;

    logic [31:0] rd;
    logic        flt;
    logic        pulse_ok;
    int          lat;

    clint_timer #(
        .PRESCALE(4),
        .SYNC_STAGES(2)
    ) dut (
        .ctrl_clk   (ctrl_clk),
        .ctrl_reset (ctrl_reset),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_fault  (mem_fault),
        .ext_irq    (ext_irq),
        .ctrl_mxip  (ctrl_mxip)
    );

    always #5 ctrl_clk = ~ctrl_clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Called at a negedge; leaves reset released at a negedge so edge counting starts at 1.
    task automatic do_reset();
        ctrl_reset = 1'b1;
        mem_valid  = 1'b0;
        ext_irq    = 1'b0;
        repeat (2) @(negedge ctrl_clk);
        ctrl_reset = 1'b0;
    endtask

    // One bus access starting at a negedge; returns at the negedge after the response cycle.
    task automatic bus_access(input logic wen, input logic [15:0] addr, input logic [3:0] strb,
                              input logic [31:0] wdata, output logic [31:0] rdata,
                              output logic fault, output int latency, output logic pulse_one);
        mem_valid = 1'b1;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wstrb = strb;
        mem_wdata = wdata;
        latency   = 0;
        do begin
            @(negedge ctrl_clk);
            latency++;
        end while (!mem_ready && latency < 20);
        rdata     = mem_rdata;
        fault     = mem_fault;
        mem_valid = 1'b0;
        mem_wen   = 1'b0;
        @(negedge ctrl_clk);
        pulse_one = !mem_ready;
    endtask

    task automatic test_reset();
        @(negedge ctrl_clk);
        checks++;
        if (ctrl_mxip !== 3'b000) begin
            errors++; $display("[TB] FAIL reset_mxip: got %b, expected 000", ctrl_mxip);
        end
        checks++;
        if (mem_ready !== 1'b0 || mem_fault !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ready_fault: got ready=%b fault=%b, expected 0 0", mem_ready, mem_fault);
        end
        checks++;
        if (mem_rdata !== 32'd0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h, expected 0", mem_rdata);
        end
        do_reset();
        bus_access(1'b0, 16'h4004, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (lat !== 1) begin
            errors++; $display("[TB] FAIL reset_read_latency: got %0d cycles, expected 1", lat);
        end
        checks++;
        if (rd !== 32'hFFFF_FFFF || flt !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_mtimecmp_hi: got rdata=%h fault=%b, expected ffffffff 0", rd, flt);
        end
        checks++;
        if (pulse_ok !== 1'b1) begin
            errors++; $display("[TB] FAIL ready_single_cycle: got ready held high, expected one-cycle pulse");
        end
        checks++;
        if (ctrl_mxip !== 3'b000) begin
            errors++; $display("[TB] FAIL post_reset_mxip: got %b, expected 000", ctrl_mxip);
        end
    endtask

    task automatic test_prescale();
        do_reset();
        repeat (40) @(negedge ctrl_clk);
        bus_access(1'b0, 16'hBFF8, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (rd !== 32'd10 || flt !== 1'b0) begin
            errors++; $display("[TB] FAIL mtime_after_40: got rdata=%0d fault=%b, expected 10 0", rd, flt);
        end
        bus_access(1'b0, 16'hBFFC, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("[TB] FAIL mtime_hi_small: got %h, expected 0", rd);
        end
    endtask

    task automatic test_timer_compare();
        int n;
        logic seen20;
        do_reset();
        bus_access(1'b1, 16'h4000, 4'hF, 32'd5, rd, flt, lat, pulse_ok);
        bus_access(1'b1, 16'h4004, 4'hF, 32'd0, rd, flt, lat, pulse_ok);
        n = 4;
        seen20 = 1'b0;
        while (n < 40) begin
            @(negedge ctrl_clk);
            n++;
            if (n == 20) seen20 = ctrl_mxip[2];
            if (ctrl_mxip[2]) break;
        end
        checks++;
        if (n !== 21) begin
            errors++; $display("[TB] FAIL timer_rise_cycle: got cycle %0d, expected 21", n);
        end
        checks++;
        if (seen20 !== 1'b0) begin
            errors++; $display("[TB] FAIL timer_early: got %b at cycle 20, expected 0", seen20);
        end
        mem_valid = 1'b1; mem_wen = 1'b1; mem_addr = 16'h4004; mem_wstrb = 4'hF; mem_wdata = 32'd1;
        @(negedge ctrl_clk);
        checks++;
        if (mem_ready !== 1'b1 || ctrl_mxip[2] !== 1'b1) begin
            errors++; $display("[TB] FAIL timer_hold_at_write: got ready=%b irq=%b, expected 1 1", mem_ready, ctrl_mxip[2]);
        end
        mem_valid = 1'b0; mem_wen = 1'b0;
        @(negedge ctrl_clk);
        checks++;
        if (ctrl_mxip[2] !== 1'b0) begin
            errors++; $display("[TB] FAIL timer_fall: got %b, expected 0", ctrl_mxip[2]);
        end
    endtask

    task automatic test_msip();
        bus_access(1'b1, 16'h0000, 4'b0001, 32'd1, rd, flt, lat, pulse_ok);
        checks++;
        if (ctrl_mxip[1] !== 1'b1) begin
            errors++; $display("[TB] FAIL msip_set: got %b, expected 1", ctrl_mxip[1]);
        end
        bus_access(1'b1, 16'h0000, 4'b0000, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (ctrl_mxip[1] !== 1'b1) begin
            errors++; $display("[TB] FAIL msip_no_strb: got %b, expected 1", ctrl_mxip[1]);
        end
        bus_access(1'b1, 16'h0000, 4'b0001, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (ctrl_mxip[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL msip_clear: got %b, expected 0", ctrl_mxip[1]);
        end
    endtask

    task automatic test_ext_irq();
        logic [10:0] seen;
        seen = '0;
        ext_irq = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge ctrl_clk);
            if (i == 5) ext_irq = 1'b0;
            seen[i] = ctrl_mxip[0];
        end
        checks++;
        if (seen !== 11'b000_0111_1100) begin
            errors++; $display("[TB] FAIL ext_irq_window: got %b, expected 00001111100", seen);
        end
    endtask

    task automatic test_fault();
        do_reset();
        bus_access(1'b1, 16'h4002, 4'hF, 32'h1234_5678, rd, flt, lat, pulse_ok);
        checks++;
        if (flt !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("[TB] FAIL misaligned_write: got fault=%b rdata=%h, expected 1 0", flt, rd);
        end
        bus_access(1'b0, 16'h4000, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (rd !== 32'hFFFF_FFFF || flt !== 1'b0) begin
            errors++; $display("[TB] FAIL cmp_unchanged: got rdata=%h fault=%b, expected ffffffff 0", rd, flt);
        end
        bus_access(1'b0, 16'h0010, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (flt !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("[TB] FAIL unmapped_read: got fault=%b rdata=%h, expected 1 0", flt, rd);
        end
        bus_access(1'b0, 16'h4002, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (flt !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("[TB] FAIL misaligned_read: got fault=%b rdata=%h, expected 1 0", flt, rd);
        end
        bus_access(1'b1, 16'h0002, 4'hF, 32'hFFFF_FFFF, rd, flt, lat, pulse_ok);
        checks++;
        if (flt !== 1'b1 || ctrl_mxip[1] !== 1'b0) begin
            errors++; $display("[TB] FAIL msip_misaligned: got fault=%b msip=%b, expected 1 0", flt, ctrl_mxip[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] pattern;
        mem_valid = 1'b1; mem_wen = 1'b0; mem_addr = 16'h4000; mem_wstrb = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ctrl_clk);
            pattern[i] = mem_ready;
        end
        checks++;
        if (pattern !== 3'b101) begin
            errors++; $display("[TB] FAIL back_to_back_ready: got %b, expected 101", pattern);
        end
        checks++;
        if (mem_rdata !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL back_to_back_rdata: got %h, expected ffffffff", mem_rdata);
        end
        mem_valid = 1'b0;
        @(negedge ctrl_clk);
    endtask

    task automatic test_snapshot();
        logic [31:0] exp_hi;
`ifdef CLINT_MTIME_SNAPSHOT_EN
        exp_hi = 32'd0;
`else
        exp_hi = 32'd1;
`endif
        do_reset();
        bus_access(1'b1, 16'hBFFC, 4'hF, 32'd0, rd, flt, lat, pulse_ok);
        bus_access(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFE, rd, flt, lat, pulse_ok);
        bus_access(1'b0, 16'hBFF8, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (rd !== 32'hFFFF_FFFF) begin
            errors++; $display("[TB] FAIL snapshot_lo: got %h, expected ffffffff", rd);
        end
        repeat (16) @(negedge ctrl_clk);
        bus_access(1'b0, 16'hBFFC, 4'h0, 32'd0, rd, flt, lat, pulse_ok);
        checks++;
        if (rd !== exp_hi) begin
            errors++; $display("[TB] FAIL snapshot_hi: got %h, expected %h", rd, exp_hi);
        end
    endtask

    task automatic test_abort();
        do_reset();
        mem_valid = 1'b1; mem_wen = 1'b1; mem_addr = 16'h0000; mem_wstrb = 4'h1; mem_wdata = 32'd1;
        @(posedge ctrl_clk);
        #2;
        ctrl_reset = 1'b1;
        @(negedge ctrl_clk);
        checks++;
        if (mem_ready !== 1'b0 || ctrl_mxip !== 3'b000) begin
            errors++; $display("[TB] FAIL abort_in_reset: got ready=%b mxip=%b, expected 0 000", mem_ready, ctrl_mxip);
        end
        mem_valid = 1'b0; mem_wen = 1'b0;
        @(negedge ctrl_clk);
        ctrl_reset = 1'b0;
        @(negedge ctrl_clk);
        checks++;
        if (mem_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_no_late_ready: got %b, expected 0", mem_ready);
        end
    endtask

    initial begin
        test_reset();
        test_prescale();
        test_timer_compare();
        test_msip();
        test_ext_irq();
        test_fault();
        test_back_to_back();
        test_snapshot();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
